// File: rtl/pwl_compress_stream_pkg.sv
// Shared constants and types for the 8-bit -> 6-bit piecewise-linear
// compressor.
//
// The 6-bit code space is split into eight 3-bit segment indices, and each
// index has eight offset levels. The middle range [-8,7] has unit step and
// sixteen levels (codes 24..39), so it is split into two index slots:
// [-8,-1] uses base 24 and [0,7] uses base 32. As a result every code is
// simply base[seg] + off.
//
// Contents: segment boundary constants, per-segment lower bound and shift,
// code bases, S1 stage record type, and a code assembly helper.
package pwl_compress_stream_pkg;

  localparam int PWL_CODE_W = 6;
  localparam int PWL_SEG_W  = 3;
  localparam int PWL_OFF_W  = 3;

  // Input-domain segment boundaries.
  localparam logic signed [7:0] PWL_BND_N120 = -8'sd120;
  localparam logic signed [7:0] PWL_BND_N56  = -8'sd56;
  localparam logic signed [7:0] PWL_BND_N24  = -8'sd24;
  localparam logic signed [7:0] PWL_BND_N8   = -8'sd8;
  localparam logic signed [7:0] PWL_BND_ZERO = 8'sd0;
  localparam logic signed [7:0] PWL_BND_P8   = 8'sd8;
  localparam logic signed [7:0] PWL_BND_P24  = 8'sd24;
  localparam logic signed [7:0] PWL_BND_P56  = 8'sd56;
  localparam logic signed [7:0] PWL_BND_P120 = 8'sd120;

  typedef logic [PWL_SEG_W-1:0]  pwl_seg_t;
  typedef logic [PWL_OFF_W-1:0]  pwl_off_t;
  typedef logic [PWL_CODE_W-1:0] pwl_code_t;

  // Code base per segment index. Slots 3 and 4 together form the unit-step
  // middle segment, which starts at base 24.
  localparam pwl_code_t PWL_SEG_BASE [8] = '{
    6'd0, 6'd8, 6'd16, 6'd24, 6'd32, 6'd40, 6'd48, 6'd56
  };

  // Value subtracted before the shift. Segment 0 is anchored at -120, so the
  // clipped region below -120 lands on a negative offset and clamps to 0.
  localparam logic signed [8:0] PWL_SEG_LO [8] = '{
    -9'sd120, -9'sd56, -9'sd24, -9'sd8, 9'sd0, 9'sd8, 9'sd24, 9'sd56
  };

  // Step size of each segment, expressed as log2.
  localparam logic [1:0] PWL_SEG_SHIFT [8] = '{
    2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3
  };

  // Contents of pipeline stage 1.
  typedef struct packed {
    pwl_seg_t seg;
    pwl_off_t off;
    logic     sat;
  } pwl_s1_t;

  function automatic pwl_code_t pwl_code(input pwl_seg_t seg, input pwl_off_t off);
    return PWL_SEG_BASE[seg] + {{(PWL_CODE_W-PWL_OFF_W){1'b0}}, off};
  endfunction

endpackage

// File: rtl/pwl_compress_stream_seg_encode.sv
// pwl_seg_encode: combinational segment and offset finder.
//
// Ports:
//   x   in   8-bit signed sample
//   seg out  3-bit segment index (0..7)
//   off out  3-bit floor level inside the segment (0..7)
module pwl_seg_encode
  import pwl_compress_stream_pkg::*;
(
  input  logic signed [7:0] x,
  output pwl_seg_t          seg,
  output pwl_off_t          off
);

  logic signed [8:0] x_ext;
  logic signed [8:0] rel;
  logic signed [8:0] shifted;

  always_comb begin
    if (x < PWL_BND_N56)       seg = 3'd0;
    else if (x < PWL_BND_N24)  seg = 3'd1;
    else if (x < PWL_BND_N8)   seg = 3'd2;
    else if (x < PWL_BND_ZERO) seg = 3'd3;
    else if (x < PWL_BND_P8)   seg = 3'd4;
    else if (x < PWL_BND_P24)  seg = 3'd5;
    else if (x < PWL_BND_P56)  seg = 3'd6;
    else                       seg = 3'd7;
  end

  // Nine bits are enough: the relative value spans -8 (x=-128 in seg 0)
  // to 71 (x=127 in seg 7).
  always_comb begin
    x_ext   = {x[7], x};
    rel     = x_ext - PWL_SEG_LO[seg];
    shifted = rel >>> PWL_SEG_SHIFT[seg];
  end

  // Clamp at both ends. The low clamp handles x < -120 in seg 0. The high
  // clamp handles x >= 120 in seg 7.
  always_comb begin
    if (shifted < 9'sd0)      off = 3'd0;
    else if (shifted > 9'sd7) off = 3'd7;
    else                      off = shifted[2:0];
  end

endmodule

// File: rtl/pwl_compress_stream.sv
// pwl_compress_stream: two-stage streaming 8-bit -> 6-bit PWL compressor
// with a saturation event counter.
//
// Ports:
//   clk, rstb               clock, synchronous active-low reset
//   in_valid/in_ready/in_data     input stream (signed 8-bit samples)
//   out_valid/out_ready/out_code  output stream (6-bit PWL codes)
//   out_sat                 the sample carried with out_code was clipped
//   clr_stat                synchronous clear of sat_cnt (wins over increment)
//   sat_cnt                 saturating count of clipped samples delivered
module pwl_compress_stream
  import pwl_compress_stream_pkg::*;
#(
  parameter int SAT_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [7:0]    in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [5:0]           out_code,
  output logic                 out_sat,
  input  logic                 clr_stat,
  output logic [SAT_CNT_W-1:0] sat_cnt
);

  logic                 s1_valid_q, s1_valid_d;
  pwl_s1_t              s1_q, s1_d;
  logic                 s2_valid_q, s2_valid_d;
  pwl_code_t            code_q, code_d;
  logic                 sat_q, sat_d;
  logic [SAT_CNT_W-1:0] cnt_q, cnt_d;

  pwl_seg_t enc_seg;
  pwl_off_t enc_off;
  logic     enc_sat;
  logic     s2_free;
  logic     s1_adv;
  logic     in_fire;
  logic     out_fire;

  pwl_seg_encode u_seg_encode (
    .x   (in_data),
    .seg (enc_seg),
    .off (enc_off)
  );

  // The segment/offset pair alone cannot tell -121 from -120, so the clip
  // flag is computed here and carried through S1.
  assign enc_sat = (in_data < PWL_BND_N120) || (in_data >= PWL_BND_P120);

  // S2 can take new data when it is empty or is being drained this cycle.
  // S1 can then move into S2, which frees S1 for a new sample.
  // in_ready is held low while reset is asserted.
  always_comb begin
    s2_free  = !s2_valid_q || out_ready;
    s1_adv   = s1_valid_q && s2_free;
    in_ready = rstb && (!s1_valid_q || s1_adv);
    in_fire  = in_valid && in_ready;
    out_fire = s2_valid_q && out_ready;
  end

  always_comb begin
    s1_valid_d = in_fire || (s1_valid_q && !s1_adv);
    s1_d       = s1_q;
    if (in_fire) begin
      s1_d.seg = enc_seg;
      s1_d.off = enc_off;
      s1_d.sat = enc_sat;
    end

    s2_valid_d = s1_adv || (s2_valid_q && !out_ready);
    code_d     = code_q;
    sat_d      = sat_q;
    if (s1_adv) begin
      code_d = pwl_code(s1_q.seg, s1_q.off);
      sat_d  = s1_q.sat;
    end

    cnt_d = cnt_q;
    if (clr_stat)
      cnt_d = '0;
    else if (out_fire && sat_q && (cnt_q != {SAT_CNT_W{1'b1}}))
      cnt_d = cnt_q + SAT_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      code_q     <= '0;
      sat_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
      s2_valid_q <= s2_valid_d;
      code_q     <= code_d;
      sat_q      <= sat_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_code  = code_q;
  assign out_sat   = sat_q;
  assign sat_cnt   = cnt_q;

endmodule

// File: tb/tb_pwl_compress_stream.sv
// Directed testbench for pwl_compress_stream. A second instance with a
// 4-bit counter exercises counter saturation.
module tb_pwl_compress_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rstb;
  logic              in_valid;
  logic signed [7:0] in_data;
  logic              out_ready;
  logic              clr_stat;
  logic              clr4;

  wire               in_ready, out_valid, out_sat;
  wire [5:0]         out_code;
  wire [15:0]        sat_cnt;
  wire               in_ready4, out_valid4, out_sat4;
  wire [5:0]         out_code4;
  wire [3:0]         sat_cnt4;

  int checks = 0;
  int errors = 0;

  pwl_compress_stream #(.SAT_CNT_W(16)) dut (
    .clk(clk), .rstb(rstb), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_code(out_code), .out_sat(out_sat), .clr_stat(clr_stat),
    .sat_cnt(sat_cnt)
  );

  pwl_compress_stream #(.SAT_CNT_W(4)) dut4 (
    .clk(clk), .rstb(rstb), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .out_valid(out_valid4), .out_ready(out_ready),
    .out_code(out_code4), .out_sat(out_sat4), .clr_stat(clr4),
    .sat_cnt(sat_cnt4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic ordy);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  // Expected values for the sweep checkpoints, computed by hand.
  int sw_val  [10] = '{-128, -120, -64, -9, -1, 0, 23, 55, 119, 127};
  int sw_code [10] = '{   0,    0,   7, 23, 31, 32, 47, 55,  63,  63};
  int sw_sat  [10] = '{   1,    0,   0,  0,  0,  0,  0,  0,   0,   1};

  // Streaming samples and their hand-computed codes.
  int st_smp  [10] = '{-100, -40, -20, -5,  3, 10, 30, 70, 100, -128};
  int st_code [10] = '{   2,  12,  18, 27, 35, 41, 49, 57,  61,    0};
  int st_sat  [10] = '{   0,   0,   0,  0,  0,  0,  0,  0,   0,    1};
  bit ready_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  // Samples for the counter test: three clipped, two normal.
  int cnt_smp [5] = '{127, 5, -128, 0, 120};

  int  v;
  int  idx;
  int  k;
  bit  stall;

  initial begin
    rstb = 1'b0;
    clr_stat = 1'b0;
    clr4 = 1'b0;
    applyStimulus(1'b0, 8'd0, 1'b1);

    // ---------------- reset state ----------------
    tick(); tick(); tick();
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_code", out_code, 0);
    checkOutput("rst_out_sat", out_sat, 0);
    checkOutput("rst_sat_cnt", sat_cnt, 0);
    checkOutput("rst_in_ready", in_ready, 0);
    rstb = 1'b1;
    #1;
    checkOutput("rel_in_ready", in_ready, 1);
    tick();

    // ---------------- full sweep, latency 2 ----------------
    $display("[TB] sweep -128..127");
    for (int i = 0; i < 258; i++) begin
      if (i >= 2) begin
        v = i - 2 - 128;
        for (int j = 0; j < 10; j++) begin
          if (sw_val[j] == v) begin
            checkOutput($sformatf("sweep_valid_%0d", v), out_valid, 1);
            checkOutput($sformatf("sweep_code_%0d", v), out_code, sw_code[j]);
            checkOutput($sformatf("sweep_sat_%0d", v), out_sat, sw_sat[j]);
          end
        end
      end
      if (i < 256) begin
        v = i - 128;
        applyStimulus(1'b1, v[7:0], 1'b1);
      end else begin
        applyStimulus(1'b0, 8'd0, 1'b1);
      end
      tick();
    end
    checkOutput("sweep_drained", out_valid, 0);

    // ---------------- stream with out_ready pattern 1,0,0,1 ----------------
    $display("[TB] stream with backpressure");
    idx = 0;
    k = 0;
    stall = 1'b0;
    for (int cyc = 0; cyc < 80 && k < 10; cyc++) begin
      if (stall) begin
        checkOutput("stall_valid", out_valid, 1);
        checkOutput("stall_code", out_code, st_code[k]);
      end
      v = st_smp[(idx < 10) ? idx : 0];
      applyStimulus(idx < 10, v[7:0], ready_pat[cyc % 4]);
      #1;
      stall = 1'b0;
      if (out_valid && out_ready) begin
        checkOutput($sformatf("stream_code_%0d", k), out_code, st_code[k]);
        checkOutput($sformatf("stream_sat_%0d", k), out_sat, st_sat[k]);
        k++;
      end else if (out_valid) begin
        stall = 1'b1;
      end
      if (in_valid && in_ready) idx++;
      tick();
    end
    applyStimulus(1'b0, 8'd0, 1'b1);
    checkOutput("stream_out_count", k, 10);
    checkOutput("stream_in_count", idx, 10);
    tick();
    checkOutput("stream_no_extra", out_valid, 0);

    // ---------------- fill while stalled ----------------
    $display("[TB] fill while stalled");
    applyStimulus(1'b1, 8'sd16, 1'b0);
    #1;
    checkOutput("fill_rdy_a", in_ready, 1);
    tick();
    applyStimulus(1'b1, 8'sd40, 1'b0);
    #1;
    checkOutput("fill_rdy_b", in_ready, 1);
    tick();
    applyStimulus(1'b1, 8'sd127, 1'b0);
    #1;
    checkOutput("fill_rdy_full", in_ready, 0);
    checkOutput("fill_hold_valid", out_valid, 1);
    checkOutput("fill_hold_code", out_code, 44);
    tick();
    applyStimulus(1'b1, -8'sd128, 1'b0);
    #1;
    checkOutput("fill_rdy_full2", in_ready, 0);
    checkOutput("fill_hold_code2", out_code, 44);
    tick();
    applyStimulus(1'b0, 8'd0, 1'b1);
    checkOutput("fill_out_a", out_code, 44);
    checkOutput("fill_out_a_sat", out_sat, 0);
    tick();
    checkOutput("fill_out_b_valid", out_valid, 1);
    checkOutput("fill_out_b", out_code, 52);
    tick();
    checkOutput("fill_no_stale", out_valid, 0);

    // ---------------- saturation counter ----------------
    $display("[TB] saturation counter");
    clr_stat = 1'b1;
    tick();
    clr_stat = 1'b0;
    checkOutput("cnt_cleared", sat_cnt, 0);
    for (int i = 0; i < 5; i++) begin
      v = cnt_smp[i];
      applyStimulus(1'b1, v[7:0], 1'b1);
      tick();
    end
    applyStimulus(1'b0, 8'd0, 1'b1);
    tick(); tick(); tick();
    checkOutput("cnt_three", sat_cnt, 3);
    applyStimulus(1'b1, -8'sd125, 1'b1);
    tick();
    applyStimulus(1'b0, 8'd0, 1'b1);
    tick();
    checkOutput("clr_race_sat_present", out_valid && out_sat, 1);
    clr_stat = 1'b1;
    tick();
    clr_stat = 1'b0;
    checkOutput("clr_race_cnt", sat_cnt, 0);

    // ---------------- 4-bit counter saturation ----------------
    $display("[TB] 4-bit counter saturation");
    clr4 = 1'b1;
    tick();
    clr4 = 1'b0;
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1'b1, -8'sd128, 1'b1);
      tick();
    end
    applyStimulus(1'b0, 8'd0, 1'b1);
    tick(); tick(); tick();
    checkOutput("cnt4_preload", sat_cnt4, 14);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 8'sd127, 1'b1);
      tick();
    end
    applyStimulus(1'b0, 8'd0, 1'b1);
    tick(); tick(); tick();
    checkOutput("cnt4_saturated", sat_cnt4, 15);
    checkOutput("cnt16_total", sat_cnt, 34);

    // ---------------- reset mid-stream ----------------
    $display("[TB] reset with both stages full");
    applyStimulus(1'b1, 8'sd50, 1'b0);
    tick();
    applyStimulus(1'b1, 8'sd60, 1'b0);
    tick();
    applyStimulus(1'b0, 8'd0, 1'b0);
    checkOutput("pre_rst_valid", out_valid, 1);
    checkOutput("pre_rst_code", out_code, 54);
    rstb = 1'b0;
    tick();
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_in_ready", in_ready, 0);
    checkOutput("midrst_out_code", out_code, 0);
    checkOutput("midrst_sat_cnt", sat_cnt, 0);
    checkOutput("midrst_sat_cnt4", sat_cnt4, 0);
    rstb = 1'b1;
    out_ready = 1'b1;
    #1;
    checkOutput("midrst_rel_ready", in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("midrst_no_stale_%0d", i), out_valid, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwl_compress_stream.md
PWL_COMPRESS_STREAM -- requirements
Module: pwl_compress_stream

Interface
REQ-001 The block SHALL have parameter SAT_CNT_W, default 16, giving the width of the saturation event counter.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rstb  input  1  reset, synchronous and active-low.
REQ-004 The block SHALL have port in_valid  input  1  an input sample is offered.
REQ-005 The block SHALL have port in_ready  output  1  the block accepts the sample this cycle.
REQ-006 The block SHALL have port in_data  input  8  the sample, signed two's complement.
REQ-007 The block SHALL have port out_valid  output  1  out_code is presented.
REQ-008 The block SHALL have port out_ready  input  1  the downstream 6-bit PWL expander accepts this cycle.
REQ-009 The block SHALL have port out_code  output  6  the compressed PWL code.
REQ-010 The block SHALL have port out_sat  output  1  the sample carried with out_code was clipped.
REQ-011 The block SHALL have port clr_stat  input  1  synchronous clear of sat_cnt.
REQ-012 The block SHALL have port sat_cnt  output  SAT_CNT_W  count of saturated samples delivered.

Function
REQ-013 The code for x = in_data SHALL be the largest PWL level <= x (floor), computed by segment:
 - x in [-128,-57]: max(0, (x+120)>>3), arithmetic shift
 - x in [-56,-25]: 8 + ((x+56)>>2)
 - x in [-24,-9]: 16 + ((x+24)>>1)
 - x in [-8,7]: 32 + x
 - x in [8,23]: 40 + ((x-8)>>1)
 - x in [24,55]: 48 + ((x-24)>>2)
 - x in [56,127]: 56 + min((x-56)>>3, 7)
REQ-014 The saturation flag SHALL be 1 exactly when x < -120 or x >= 120.
REQ-015 The datapath SHALL be a two-stage pipeline: S1 registers the segment index and offset; S2 registers out_code and out_sat.
REQ-016 An input transfer SHALL occur when in_valid and in_ready are both 1; an output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-017 When out_ready is held 1, a sample accepted in cycle N SHALL appear on out_valid/out_code in cycle N+2, at one sample per cycle throughput.
REQ-018 Each stage SHALL load when it is empty or when its content moves on in the same cycle; in_ready SHALL be 1 when S1 is empty or S1 advances this cycle.
REQ-019 While out_valid=1 and out_ready=0, out_code and out_sat SHALL hold stable, and no sample SHALL be dropped or duplicated.
REQ-020 With both stages full and out_ready=0, in_ready SHALL be 0 and in_data SHALL be ignored.
REQ-021 sat_cnt SHALL increment by 1 on each output transfer with out_sat=1, and SHALL saturate at all-ones without wrapping.
REQ-022 If clr_stat=1 and a saturated output transfer occur in the same cycle, clr_stat SHALL win and sat_cnt SHALL be 0.
REQ-023 Samples SHALL leave in acceptance order.

Reset
REQ-024 While rstb=0 at a clock edge, both stage valid flags, out_valid, out_code, out_sat and sat_cnt SHALL become 0, and in_ready SHALL be 0.
REQ-025 A reset asserted mid-stream SHALL discard all in-flight samples.
REQ-026 in_ready SHALL be 1 in the first cycle after rstb returns to 1.

Structure
REQ-027 A shared package SHALL hold the segment boundary constants (-120, -56, -24, -8, 8, 24, 56, 120), the per-segment code bases (0, 8, 16, 24, 40, 48, 56) and the code width 6.
REQ-028 The block SHALL contain one combinational sub-module, pwl_seg_encode (8-bit signed in; 3-bit segment and 3-bit offset out), instantiated in S1.

Verification
REQ-029 The bench SHALL drive a sweep of -128..127 with out_ready=1 and check codes -128->0 (sat), -120->0, -64->7, -9->23, -1->31, 0->32, 23->47, 55->55, 119->63, 127->63 (sat), each at latency 2.
REQ-030 The bench SHALL stream 10 samples with out_ready toggled 1,0,0,1 and check 10 in-order outputs, no loss, and out_code stable while stalled.
REQ-031 The bench SHALL hold out_ready=0 with in_valid=1 and check that in_ready drops after 2 accepts, and that in_data changes while stalled do not appear at the output.
REQ-032 The bench SHALL send 3 saturated and 2 normal samples and check sat_cnt=3; it SHALL then assert clr_stat together with a saturated transfer and check sat_cnt=0.
REQ-033 The bench SHALL preload sat_cnt near all-ones using SAT_CNT_W=4, send 20 saturated samples and check sat_cnt=15.
REQ-034 The bench SHALL assert rstb=0 with both stages full and check that out_valid=0 next cycle and no stale code emerges after release.
